// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Bridges a CPU-side valid/ready request port to an APB bus. It serves four
// slaves. Each accepted request is address-decoded to one slave select and
// driven through SETUP -> ACCESS. The ACCESS phase waits on that slave's
// PREADY for at most TIMEOUT cycles. The result then comes back on a
// one-cycle response strobe.
//
// Ports
//   PCLK, PRESET             bus clock (rising edge), async active-low reset
//   req_valid/req_ready      request handshake; ready is high only in IDLE
//   req_addr/req_write/
//   req_wdata                request address, direction (1 = write), data
//   rsp_valid                one-cycle response strobe, no backpressure
//   rsp_rdata/rsp_err        read data (0 on write/error), error flag
//   PADDR/PWRITE/PWDATA      APB address, direction, write data (registered)
//   PSEL/PENABLE             APB one-hot select and enable (registered)
//   PRDATA0..3, PREADY       per-slave read data and ready
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    input  logic               req_write,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [31:0]        PADDR,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    output logic               PENABLE,
    output logic [NUM_SLV-1:0] PSEL,
    input  logic [31:0]        PRDATA0,
    input  logic [31:0]        PRDATA1,
    input  logic [31:0]        PRDATA2,
    input  logic [31:0]        PRDATA3,
    input  logic [NUM_SLV-1:0] PREADY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  idx;
    logic [7:0]  cnt;
    logic        dec_ok;
    logic        pready_sel;
    logic [31:0] prdata_sel;

    // The peripheral window is 0x1000_0000-0x1000_3FFF, with 4 KB per slave.
    assign dec_ok     = (req_addr[31:14] == 18'h04000);
    assign req_ready  = (state == IDLE);
    assign pready_sel = PREADY[idx];

    // NOTE: every signal assigned in always_comb gets a default first.
    // Otherwise a missed branch infers a latch.
    always_comb begin
        prdata_sel = '0;
        case (idx)
            2'd0:    prdata_sel = PRDATA0;
            2'd1:    prdata_sel = PRDATA1;
            2'd2:    prdata_sel = PRDATA2;
            default: prdata_sel = PRDATA3;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the edge, whatever the statement
    // order.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        PADDR  <= req_addr;
                        PWRITE <= req_write;
                        PWDATA <= req_wdata;
                        if (dec_ok) begin
                            idx   <= req_addr[13:12];
                            PSEL  <= NUM_SLV'(1) << req_addr[13:12];
                            state <= SETUP;
                        end else begin
                            // A decode miss never touches the bus. It answers directly.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked before the timeout. A ready in the
                    // last allowed cycle still completes the transfer.
                    if (pready_sel) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? 32'h0 : prdata_sel;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Directed bench for apb_master with TIMEOUT = 16. Inputs change and outputs
// are sampled on the falling edge. The value sampled after the N-th rising
// edge that follows acceptance belongs to cycle N.
// ---------------------------------------------------------------------------
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic [3:0]  PREADY;

    int n_cmp = 0;
    int n_mis = 0;

    apb_master #(.NUM_SLV(4), .TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PENABLE   (PENABLE),
        .PSEL      (PSEL),
        .PRDATA0   (PRDATA0),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2),
        .PRDATA3   (PRDATA3),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic request(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        PRDATA0 = 32'hDEAD_0000; PRDATA1 = 32'hDEAD_0001;
        PRDATA2 = 32'hDEAD_0002; PRDATA3 = 32'hDEAD_0003;
        PREADY = 4'b0000;

        // ---- Reset state. req_ready is high during reset, but nothing is captured.
        @(negedge PCLK);
        request(32'h1000_0000, 1'b1, 32'h1234_5678);
        check("rst_ready", req_ready, 1);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        tick();
        check("rst_no_capture_psel", PSEL, 0);
        check("rst_no_capture_paddr", PADDR, 0);
        req_valid = 1'b0;
        PRESET = 1'b1;
        tick();
        check("post_rst_psel", PSEL, 0);
        check("post_rst_rsp_valid", rsp_valid, 0);

        // ---- Write to slave 0 with a registered (GPIO-style) PREADY.
        request(32'h1000_0000, 1'b1, 32'h0000_00FF);
        check("wr_c0_ready", req_ready, 1);
        tick(); // cycle 1
        req_valid = 1'b0;
        check("wr_c1_psel", PSEL, 4'b0001);
        check("wr_c1_penable", PENABLE, 0);
        check("wr_c1_paddr", PADDR, 32'h1000_0000);
        check("wr_c1_pwrite", PWRITE, 1);
        check("wr_c1_pwdata", PWDATA, 32'h0000_00FF);
        check("wr_c1_ready", req_ready, 0);
        tick(); // cycle 2
        check("wr_c2_psel", PSEL, 4'b0001);
        check("wr_c2_penable", PENABLE, 1);
        tick(); // cycle 3
        check("wr_c3_psel", PSEL, 4'b0001);
        check("wr_c3_penable", PENABLE, 1);
        check("wr_c3_rsp_valid", rsp_valid, 0);
        PREADY = 4'b0001;
        tick(); // cycle 4, trailing PREADY still high
        check("wr_c4_rsp_valid", rsp_valid, 1);
        check("wr_c4_rsp_err", rsp_err, 0);
        check("wr_c4_rsp_rdata", rsp_rdata, 0);
        check("wr_c4_psel", PSEL, 0);
        check("wr_c4_penable", PENABLE, 0);
        tick(); // cycle 5
        PREADY = 4'b0000;
        check("wr_c5_rsp_valid", rsp_valid, 0);
        check("wr_c5_ready", req_ready, 1);
        check("wr_c5_psel", PSEL, 0);

        // ---- Read from slave 1 with a combinational PREADY.
        PRDATA1 = 32'h0000_00A5;
        PREADY  = 4'b0010;
        request(32'h1000_1004, 1'b0, 32'h0);
        tick(); // cycle 1
        req_valid = 1'b0;
        check("rd_c1_psel", PSEL, 4'b0010);
        check("rd_c1_penable", PENABLE, 0);
        tick(); // cycle 2
        check("rd_c2_psel", PSEL, 4'b0010);
        check("rd_c2_penable", PENABLE, 1);
        check("rd_c2_rsp_valid", rsp_valid, 0);
        tick(); // cycle 3
        check("rd_c3_rsp_valid", rsp_valid, 1);
        check("rd_c3_rsp_rdata", rsp_rdata, 32'h0000_00A5);
        check("rd_c3_rsp_err", rsp_err, 0);
        tick(); // cycle 4
        PREADY = 4'b0000;
        check("rd_c4_rsp_valid", rsp_valid, 0);
        check("rd_c4_rdata_hold", rsp_rdata, 32'h0000_00A5);

        // ---- Decode error: no bus activity, and the response comes in cycle 1.
        request(32'h2000_0000, 1'b0, 32'h0);
        tick(); // cycle 1
        req_valid = 1'b0;
        check("dec_c1_rsp_valid", rsp_valid, 1);
        check("dec_c1_rsp_err", rsp_err, 1);
        check("dec_c1_rsp_rdata", rsp_rdata, 0);
        check("dec_c1_psel", PSEL, 0);
        tick(); // cycle 2
        check("dec_c2_rsp_valid", rsp_valid, 0);
        check("dec_c2_psel", PSEL, 0);
        check("dec_c2_ready", req_ready, 1);

        // ---- Load nonzero rdata so the timeout must clear it (slave 1 again).
        PREADY = 4'b0010;
        request(32'h1000_1000, 1'b0, 32'h0);
        tick(); req_valid = 1'b0;
        tick(); tick();
        check("pre_to_rdata", rsp_rdata, 32'h0000_00A5);
        tick();
        // ---- Timeout on slave 3. Other slaves drive PREADY high, and it must be ignored.
        PREADY = 4'b0111;
        request(32'h1000_3000, 1'b0, 32'h0);
        tick(); // cycle 1
        req_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("to_c%0d_psel", c), PSEL, 4'b1000);
            check($sformatf("to_c%0d_rsp_valid", c), rsp_valid, 0);
            tick();
        end
        // cycle 18
        check("to_c18_rsp_valid", rsp_valid, 1);
        check("to_c18_rsp_err", rsp_err, 1);
        check("to_c18_rsp_rdata", rsp_rdata, 0);
        check("to_c18_psel", PSEL, 0);
        check("to_c18_penable", PENABLE, 0);
        tick();
        check("to_c19_rsp_valid", rsp_valid, 0);

        // ---- The same request with PREADY arriving in the last allowed cycle (17).
        PREADY  = 4'b0000;
        PRDATA3 = 32'h3333_3333;
        request(32'h1000_3000, 1'b0, 32'h0);
        tick(); // cycle 1
        req_valid = 1'b0;
        for (int c = 1; c <= 16; c++) tick();
        // cycle 17
        check("tov_c17_psel", PSEL, 4'b1000);
        check("tov_c17_rsp_valid", rsp_valid, 0);
        PREADY = 4'b1000;
        tick(); // cycle 18
        check("tov_c18_rsp_valid", rsp_valid, 1);
        check("tov_c18_rsp_err", rsp_err, 0);
        check("tov_c18_rsp_rdata", rsp_rdata, 32'h3333_3333);
        tick();
        PREADY = 4'b0000;

        // ---- Back-to-back zero-wait reads with req_valid held high.
        PRDATA0 = 32'h1111_0000;
        PRDATA2 = 32'h2222_0002;
        PREADY  = 4'b0101;
        request(32'h1000_0010, 1'b0, 32'h0);
        tick(); // cycle 1
        req_addr = 32'h1000_2008;  // second request is presented while busy
        check("b2b_c1_psel", PSEL, 4'b0001);
        check("b2b_c1_paddr", PADDR, 32'h1000_0010);
        tick(); // cycle 2
        check("b2b_c2_paddr", PADDR, 32'h1000_0010);
        check("b2b_c2_ready", req_ready, 0);
        tick(); // cycle 3
        check("b2b_c3_rsp_valid", rsp_valid, 1);
        check("b2b_c3_rsp_rdata", rsp_rdata, 32'h1111_0000);
        tick(); // cycle 4: second acceptance edge ends this cycle
        check("b2b_c4_rsp_valid", rsp_valid, 0);
        check("b2b_c4_ready", req_ready, 1);
        tick(); // cycle 5
        req_valid = 1'b0;
        check("b2b_c5_psel", PSEL, 4'b0100);
        check("b2b_c5_paddr", PADDR, 32'h1000_2008);
        tick(); // cycle 6
        check("b2b_c6_penable", PENABLE, 1);
        check("b2b_c6_rsp_valid", rsp_valid, 0);
        tick(); // cycle 7
        check("b2b_c7_rsp_valid", rsp_valid, 1);
        check("b2b_c7_rsp_rdata", rsp_rdata, 32'h2222_0002);
        check("b2b_c7_rsp_err", rsp_err, 0);
        tick(); // cycle 8
        check("b2b_c8_rsp_valid", rsp_valid, 0);
        check("b2b_c8_psel", PSEL, 0);

        // ---- Reset in the middle of ACCESS on slave 1.
        PREADY = 4'b0000;
        request(32'h1000_1000, 1'b1, 32'hCAFE_F00D);
        tick(); // cycle 1
        req_valid = 1'b0;
        tick(); // cycle 2
        check("rstm_c2_penable", PENABLE, 1);
        check("rstm_c2_psel", PSEL, 4'b0010);
        PRESET = 1'b0;
        #1;
        check("rstm_async_psel", PSEL, 0);
        check("rstm_async_penable", PENABLE, 0);
        check("rstm_async_rsp_valid", rsp_valid, 0);
        PREADY = 4'b0010;
        tick();
        check("rstm_hold_rsp_valid", rsp_valid, 0);
        check("rstm_hold_ready", req_ready, 1);
        PRESET = 1'b1;
        tick();
        check("rstm_rel1_rsp_valid", rsp_valid, 0);
        check("rstm_rel1_psel", PSEL, 0);
        tick();
        check("rstm_rel2_rsp_valid", rsp_valid, 0);
        PRDATA1 = 32'h0000_5A5A;
        request(32'h1000_1000, 1'b0, 32'h0);
        tick(); // cycle 1
        req_valid = 1'b0;
        check("rstm_new_c1_psel", PSEL, 4'b0010);
        tick(); tick(); // cycle 3
        check("rstm_new_c3_rsp_valid", rsp_valid, 1);
        check("rstm_new_c3_rsp_rdata", rsp_rdata, 32'h0000_5A5A);
        check("rstm_new_c3_rsp_err", rsp_err, 0);
        tick();
        check("rstm_new_c4_rsp_valid", rsp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
